// File: rtl/add_fn_arb_pkg.sv
// Shared types and constants for add_fn_arbiter.
// ADD_FN_ARB_OUT_REG_EN selects the registered-adder-output variant (adds state REG).
package add_fn_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    REG  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_REQ             = 8;
  localparam int FLOAT_CONTROL_WIDTH = 1;

`ifdef ADD_FN_ARB_OUT_REG_EN
  localparam int ADD_FN_ARB_LATENCY = 3;
`else
  localparam int ADD_FN_ARB_LATENCY = 2;
`endif

  localparam logic [2:0] RM_NEAR_EVEN    = 3'd0;
  localparam logic [2:0] RM_MIN_MAG      = 3'd1;
  localparam logic [2:0] RM_MIN          = 3'd2;
  localparam logic [2:0] RM_MAX          = 3'd3;
  localparam logic [2:0] RM_NEAR_MAX_MAG = 3'd4;

endpackage

// File: rtl/addFN.sv
// Combinational IEEE-754 style adder/subtractor; flags are {invalid, infinite, overflow, underflow, inexact}.
// i_control[0] selects tininess detection after rounding (1) or before (0).
module addFN
  import add_fn_arb_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24
) (
  input  logic [FLOAT_CONTROL_WIDTH-1:0] i_control,
  input  logic                           i_sub_op,
  input  logic [expWidth+sigWidth-1:0]   i_a,
  input  logic [expWidth+sigWidth-1:0]   i_b,
  input  logic [2:0]                     i_rounding_mode,
  output logic [expWidth+sigWidth-1:0]   o_out,
  output logic [4:0]                     o_exception_flags
);

  localparam int W  = expWidth + sigWidth;
  localparam int FW = sigWidth - 1;
  localparam int X  = sigWidth + 3;
  localparam int EW = expWidth + 1;
  localparam logic [expWidth-1:0] EXP_ONES = '1;

  function automatic int lzc(input logic [X-1:0] v);
    lzc = X;
    for (int i = 0; i < X; i++) if (v[i]) lzc = X - 1 - i;
  endfunction

  logic                w_sa, w_sb;
  logic [expWidth-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [FW-1:0]       w_fa, w_fb;
  logic                w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_snan, w_inf_inf;

  assign w_sa     = i_a[W-1];
  assign w_sb     = i_b[W-1] ^ i_sub_op;
  assign w_ea     = i_a[W-2 -: expWidth];
  assign w_eb     = i_b[W-2 -: expWidth];
  assign w_fa     = i_a[FW-1:0];
  assign w_fb     = i_b[FW-1:0];
  assign w_ea_eff = (w_ea == '0) ? expWidth'(1) : w_ea;
  assign w_eb_eff = (w_eb == '0) ? expWidth'(1) : w_eb;
  assign w_nan_a  = (w_ea == EXP_ONES) && (w_fa != '0);
  assign w_nan_b  = (w_eb == EXP_ONES) && (w_fb != '0);
  assign w_inf_a  = (w_ea == EXP_ONES) && (w_fa == '0);
  assign w_inf_b  = (w_eb == EXP_ONES) && (w_fb == '0);
  assign w_snan   = (w_nan_a && !w_fa[FW-1]) || (w_nan_b && !w_fb[FW-1]);
  assign w_inf_inf = w_inf_a && w_inf_b && (w_sa != w_sb);

  // Order operands by magnitude so the aligned subtraction never goes negative
  logic                w_swap, w_s_big, w_s_small;
  logic [expWidth-1:0] w_e_big, w_d;
  logic [sigWidth-1:0] w_m_big, w_m_small;

  assign w_swap    = (i_b[W-2:0] > i_a[W-2:0]);
  assign w_s_big   = w_swap ? w_sb : w_sa;
  assign w_s_small = w_swap ? w_sa : w_sb;
  assign w_e_big   = w_swap ? w_eb_eff : w_ea_eff;
  assign w_d       = w_swap ? (w_eb_eff - w_ea_eff) : (w_ea_eff - w_eb_eff);
  assign w_m_big   = w_swap ? {|w_eb, w_fb} : {|w_ea, w_fa};
  assign w_m_small = w_swap ? {|w_ea, w_fa} : {|w_eb, w_fb};

  logic [X-1:0]      w_big_ext, w_small_ext, w_small_al, w_norm;
  logic [2*X-1:0]    w_shift_wide;
  logic [X:0]        w_sum;
  logic [EW-1:0]     w_exp_n;
  logic [EW+FW-1:0]  w_packed;
  logic              w_sticky, w_eff_sub, w_up, w_inexact, w_tiny, w_ovf, w_ovf_max;
  logic              w_lsb, w_g, w_rs;
  int                w_lz, w_shl;

  always_comb begin
    w_big_ext    = {w_m_big, 3'b000};
    w_small_ext  = {w_m_small, 3'b000};
    w_shift_wide = {w_small_ext, {X{1'b0}}} >> w_d;
    w_sticky     = (int'(w_d) >= X) ? (|w_small_ext) : (|w_shift_wide[X-1:0]);
    w_small_al   = w_shift_wide[2*X-1 -: X] | {{(X-1){1'b0}}, w_sticky};
    w_eff_sub    = w_s_big ^ w_s_small;
    w_sum        = w_eff_sub ? ({1'b0, w_big_ext} - {1'b0, w_small_al})
                             : ({1'b0, w_big_ext} + {1'b0, w_small_al});
    w_lz         = lzc(w_sum[X-1:0]);
    w_shl        = 0;

    // Left shift stops at the minimum exponent, leaving a subnormal
    if (w_sum[X]) begin
      w_norm  = {w_sum[X:2], w_sum[1] | w_sum[0]};
      w_exp_n = {1'b0, w_e_big} + EW'(1);
    end else begin
      w_shl   = (w_lz < int'(w_e_big) - 1) ? w_lz : int'(w_e_big) - 1;
      w_norm  = w_sum[X-1:0] << w_shl;
      w_exp_n = w_norm[X-1] ? EW'(int'(w_e_big) - w_shl) : '0;
    end

    w_lsb     = w_norm[3];
    w_g       = w_norm[2];
    w_rs      = |w_norm[1:0];
    w_inexact = w_g | w_rs;
    case (i_rounding_mode)
      RM_MIN_MAG:      w_up = 1'b0;
      RM_MIN:          w_up = w_s_big & w_inexact;
      RM_MAX:          w_up = ~w_s_big & w_inexact;
      RM_NEAR_MAX_MAG: w_up = w_g;
      default:         w_up = w_g & (w_rs | w_lsb);
    endcase

    // Carry out of the fraction lands in the exponent field
    w_packed  = {w_exp_n, w_norm[X-2:3]} + (EW+FW)'(w_up);
    w_ovf     = (w_packed[EW+FW-1:FW] >= {1'b0, EXP_ONES});
    w_ovf_max = (i_rounding_mode == RM_MIN_MAG) ||
                ((i_rounding_mode == RM_MIN) && !w_s_big) ||
                ((i_rounding_mode == RM_MAX) && w_s_big);
    w_tiny    = i_control[0] ? (w_packed[EW+FW-1:FW] == '0) : (w_exp_n == '0);

    o_out             = {w_s_big, w_packed[EW+FW-2:0]};
    o_exception_flags = {3'b000, w_tiny & w_inexact, w_inexact};
    if (w_nan_a || w_nan_b || w_inf_inf) begin
      o_out             = {1'b0, EXP_ONES, 1'b1, {(FW-1){1'b0}}};
      o_exception_flags = {w_snan | w_inf_inf, 4'b0000};
    end else if (w_inf_a || w_inf_b) begin
      o_out             = {w_inf_a ? w_sa : w_sb, EXP_ONES, {FW{1'b0}}};
      o_exception_flags = '0;
    end else if (w_sum == '0) begin
      o_out             = {w_eff_sub ? (i_rounding_mode == RM_MIN) : w_s_big, {(W-1){1'b0}}};
      o_exception_flags = '0;
    end else if (w_ovf) begin
      o_out             = w_ovf_max ? {w_s_big, EXP_ONES - expWidth'(1), {FW{1'b1}}}
                                    : {w_s_big, EXP_ONES, {FW{1'b0}}};
      o_exception_flags = 5'b00101;
    end
  end

endmodule

// File: rtl/add_fn_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDXW-1:0]    o_grant_idx,
  output logic               o_valid
);

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_valid                                   = 1'b1;
        o_grant[(int'(i_ptr) + k) % NUM_REQ]      = 1'b1;
        o_grant_idx = IDXW'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/add_fn_arbiter.sv
// Round-robin sequencer sharing one addFN between NUM_REQ go/done requesters.
// ADD_FN_ARB_OUT_REG_EN inserts REG between EXEC and DONE to register the raw adder output.
//
// state | meaning
// IDLE  | waiting; grants first go at/after rr_ptr and latches its operands
// EXEC  | adder evaluates latched operands; result captured
// REG   | (macro only) pipeline register copied to out
// DONE  | done pulse to granted requester; rr_ptr advances
module add_fn_arbiter
  import add_fn_arb_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int NUM_REQ  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [FLOAT_CONTROL_WIDTH-1:0]          control,
  input  logic [NUM_REQ-1:0]                      go,
  input  logic [NUM_REQ-1:0]                      sub_op,
  input  logic [NUM_REQ*(expWidth+sigWidth)-1:0]  a,
  input  logic [NUM_REQ*(expWidth+sigWidth)-1:0]  b,
  input  logic [NUM_REQ*3-1:0]                    rounding_mode,
  output logic [NUM_REQ-1:0]                      done,
  output logic [expWidth+sigWidth-1:0]            out,
  output logic [4:0]                              exception_flags,
  output logic                                    busy
);

  localparam int W    = expWidth + sigWidth;
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              r_state, w_next_state;
  logic [IDXW-1:0]     r_rr_ptr, r_grant_idx, w_grant_idx;
  logic [NUM_REQ-1:0]  r_grant, w_grant;
  logic                w_req_valid;
  logic [W-1:0]        r_op_a, r_op_b, r_out, w_add_out;
  logic                r_op_sub;
  logic [2:0]          r_op_rm;
  logic [4:0]          r_flags, w_add_flags;
`ifdef ADD_FN_ARB_OUT_REG_EN
  logic [W-1:0]        r_pipe_out;
  logic [4:0]          r_pipe_flags;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
    .i_req       (go),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_valid     (w_req_valid)
  );

  addFN #(.expWidth(expWidth), .sigWidth(sigWidth)) u_add (
    .i_control         (control),
    .i_sub_op          (r_op_sub),
    .i_a               (r_op_a),
    .i_b               (r_op_b),
    .i_rounding_mode   (r_op_rm),
    .o_out             (w_add_out),
    .o_exception_flags (w_add_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_req_valid) w_next_state = EXEC;
`ifdef ADD_FN_ARB_OUT_REG_EN
      EXEC: w_next_state = REG;
`else
      EXEC: w_next_state = DONE;
`endif
      REG:  w_next_state = DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
      r_grant      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_sub     <= 1'b0;
      r_op_rm      <= '0;
      r_out        <= '0;
      r_flags      <= '0;
`ifdef ADD_FN_ARB_OUT_REG_EN
      r_pipe_out   <= '0;
      r_pipe_flags <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_req_valid) begin
          r_grant     <= w_grant;
          r_grant_idx <= w_grant_idx;
          r_op_a      <= a[int'(w_grant_idx)*W +: W];
          r_op_b      <= b[int'(w_grant_idx)*W +: W];
          r_op_sub    <= sub_op[w_grant_idx];
          r_op_rm     <= rounding_mode[int'(w_grant_idx)*3 +: 3];
        end
        EXEC: begin
`ifdef ADD_FN_ARB_OUT_REG_EN
          r_pipe_out   <= w_add_out;
          r_pipe_flags <= w_add_flags;
`else
          r_out        <= w_add_out;
          r_flags      <= w_add_flags;
`endif
        end
        REG: begin
`ifdef ADD_FN_ARB_OUT_REG_EN
          r_out   <= r_pipe_out;
          r_flags <= r_pipe_flags;
`endif
        end
        DONE: r_rr_ptr <= (int'(r_grant_idx) == NUM_REQ - 1) ? '0 : r_grant_idx + IDXW'(1);
        default: ;
      endcase
    end
  end

  assign done            = (r_state == DONE) ? r_grant : '0;
  assign busy            = (r_state != IDLE);
  assign out             = r_out;
  assign exception_flags = r_flags;

endmodule

// File: tb/tb_add_fn_arbiter.sv
// Directed bench for add_fn_arbiter (2 requesters, binary32); latency follows ADD_FN_ARB_OUT_REG_EN.
module tb_add_fn_arbiter;
  import add_fn_arb_pkg::*;

  localparam int LAT = ADD_FN_ARB_LATENCY;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  control;
  logic [1:0]  go, sub_op;
  logic [63:0] a, b;
  logic [5:0]  rounding_mode;
  logic [1:0]  done;
  logic [31:0] out;
  logic [4:0]  exception_flags;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  add_fn_arbiter #(.expWidth(8), .sigWidth(24), .NUM_REQ(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .control         (control),
    .go              (go),
    .sub_op          (sub_op),
    .a               (a),
    .b               (b),
    .rounding_mode   (rounding_mode),
    .done            (done),
    .out             (out),
    .exception_flags (exception_flags),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] av, input logic [31:0] bv,
                         input logic sub, input logic [2:0] rm);
    a[idx*32 +: 32]            = av;
    b[idx*32 +: 32]            = bv;
    sub_op[idx]                = sub;
    rounding_mode[idx*3 +: 3]  = rm;
  endtask

  task automatic run_one(input string tag, input int idx, input logic [31:0] av, input logic [31:0] bv,
                         input logic sub, input logic [2:0] rm,
                         input logic [31:0] exp_out, input logic [4:0] exp_fl);
    set_req(idx, av, bv, sub, rm);
    go[idx] = 1'b1;
    tick();
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_done_early"}, 64'(done), 64'(0));
    for (int k = 1; k < LAT - 1; k++) begin
      tick();
      check({tag, "_done_mid"}, 64'(done), 64'(0));
    end
    tick();
    check({tag, "_done"}, 64'(done), 64'(1) << idx);
    check({tag, "_out"}, 64'(out), 64'(exp_out));
    check({tag, "_flags"}, 64'(exception_flags), 64'(exp_fl));
    go[idx] = 1'b0;
    tick();
    check({tag, "_done_drop"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  // Both requesters hold go; grants alternate 0,1,0,1 starting from rr_ptr=0
  task automatic both_held(input string tag, input int n_ops);
    logic [1:0] exp_done;
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0);
    set_req(1, 32'h4040_0000, 32'h4040_0000, 1'b1, 3'd0);
    go = 2'b11;
    for (int k = 0; k < n_ops * (LAT + 1); k++) begin
      tick();
      if (k % (LAT + 1) == LAT - 1) begin
        exp_done = ((k / (LAT + 1)) % 2 == 0) ? 2'b01 : 2'b10;
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_out"}, 64'(out), exp_done[0] ? 64'h4040_0000 : 64'h0);
      end else begin
        check({tag, "_nodone"}, 64'(done), 64'(0));
      end
    end
    go = 2'b00;
    tick();
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    reset         = 1'b0;
    control       = 1'b0;
    go            = '0;
    sub_op        = '0;
    a             = '0;
    b             = '0;
    rounding_mode = '0;
    tick();
    tick();
    check("rst_done",  64'(done), 64'(0));
    check("rst_out",   64'(out), 64'(0));
    check("rst_flags", 64'(exception_flags), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    reset = 1'b1;
    tick();

    run_one("add_1p2",   0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0, 32'h4040_0000, 5'b00000);
    run_one("sub_zero",  1, 32'h4040_0000, 32'h4040_0000, 1'b1, 3'd0, 32'h0000_0000, 5'b00000);
    run_one("inf_inf",   0, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'd0, 32'h7FC0_0000, 5'b10000);
    run_one("tie_rne",   1, 32'h3F80_0000, 32'h3380_0000, 1'b0, 3'd0, 32'h3F80_0000, 5'b00001);
    run_one("tie_rup",   0, 32'h3F80_0000, 32'h3380_0000, 1'b0, 3'd3, 32'h3F80_0001, 5'b00001);
    run_one("mixed_sgn", 1, 32'h3FC0_0000, 32'hBE80_0000, 1'b0, 3'd0, 32'h3FA0_0000, 5'b00000);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    both_held("rr", 4);

    // Leave rr_ptr at 1 and out nonzero, then abandon an operation in EXEC
    run_one("pre_rst", 0, 32'h3FC0_0000, 32'hBE80_0000, 1'b0, 3'd0, 32'h3FA0_0000, 5'b00000);
    go[0] = 1'b1;
    tick();
    check("midrst_exec", 64'(busy), 64'(1));
    reset = 1'b0;
    go    = 2'b00;
    tick();
    check("midrst_done",  64'(done), 64'(0));
    check("midrst_out",   64'(out), 64'(0));
    check("midrst_flags", 64'(exception_flags), 64'(0));
    check("midrst_busy",  64'(busy), 64'(0));
    reset = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      check("midrst_quiet", 64'(done), 64'(0));
    end
    both_held("post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_fn_arbiter.md
# add_fn_arbiter

Round-robin arbiter and sequencer that shares one `addFN` floating-point adder between `NUM_REQ` requesters. It uses the standard go/done handshake. It captures the granted requester's operands and registers the adder result. It then pulses that requester's `done` for one cycle. It sits between several Calyx-scheduled groups and a single adder instance in area-constrained float designs.

## Interface
- `expWidth`, 8, exponent width passed to `addFN`
- `sigWidth`, 24, significand width passed to `addFN`; W = expWidth+sigWidth
- `NUM_REQ`, 2, number of requesters (2..8)
- `clk` input 1 clock; all state updates on rising edge
- `reset` input 1 synchronous, active-low; state is cleared on a rising edge where `reset`=0
- `control` input `floatControlWidth` shared adder control, passed through unregistered
- `go` input NUM_REQ per-requester request; held high until that requester's `done`
- `sub_op` input NUM_REQ per-requester subtract select
- `a`, `b` input NUM_REQ*W per-requester operands, requester i at bits [i*W +: W]
- `rounding_mode` input NUM_REQ*3 per-requester rounding mode
- `done` output NUM_REQ one-hot pulse, one cycle, to the served requester
- `out` output W result register; valid while `done` is high, holds until the next result
- `exception_flags` output 5 flags register; updates together with `out`
- `busy` output 1 high whenever state ≠ IDLE

## Operation
- States:
  - IDLE: if any `go` bit is set, grant the first set bit at or after `rr_ptr` (wrapping), latch that requester's `a`, `b`, `sub_op` and `rounding_mode` into operand registers, then go to EXEC.
  - EXEC: the adder evaluates the latched operands combinationally. Latch the adder result and flags into `out` and `exception_flags`, then go to DONE.
  - DONE: assert `done[grant]`, set `rr_ptr` to (grant+1) mod NUM_REQ, then go to IDLE.
- Requesters see `out` change only at the EXEC→DONE edge.
- Inputs of non-granted requesters are ignored.
- A `go` bit that drops before its `done` is a protocol violation. The arbiter does not abort; it completes the operation and still pulses `done`.
- In IDLE, a requester whose `go` is still high one cycle after its `done` is re-granted as a new request.
- Simultaneous requests: at most one grant per IDLE cycle. With all NUM_REQ requesters continuously requesting, each is served exactly once per NUM_REQ operations.
- A requester that arrives while `busy`=1 waits; there is no queueing beyond its held `go`.
- Reset values: state=IDLE, `rr_ptr`=0, `done`=0, `out`=0, `exception_flags`=0, `busy`=0, operand registers=0.
- Reset mid-operation: the operation is abandoned and no `done` is issued. The requester must re-assert `go` after reset.

## Timing
- `go` sampled high in IDLE at edge t → `done` high during cycle t+2 (latency 2, 3 with the output-register macro).
- Back-to-back throughput: one result per 3 cycles (IDLE, EXEC, DONE); 4 with the macro.
- `done` is never high for more than one consecutive cycle, and never for two requesters at once.
- `control` is combinational into the adder and must be stable from grant through the result latch.

## Configuration
- `ADD_FN_ARB_OUT_REG_EN`:
  - Defined: insert a state REG between EXEC and DONE. EXEC stores the raw adder output in a pipeline register; REG copies it to `out`. This breaks the adder path for timing closure. Latency becomes 3 and the rotation is unchanged.
  - Undefined: the state sequence is IDLE/EXEC/DONE with latency 2.

## Structure
- Package `add_fn_arb_pkg`:
  - state enum (IDLE, EXEC, REG, DONE)
  - `ADD_FN_ARB_LATENCY` constant, resolved from the macro
  - `MAX_REQ`=8
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and its index.
- A single `addFN` instance is driven from the operand registers.

## Test plan
All values use expWidth=8, sigWidth=24, round-to-nearest-even.
- Single request: req0 go, a=0x3F800000, b=0x40000000, sub=0 → `done[0]` at t+2, `out`=0x40400000, flags=0.
- Subtract to zero: req1 a=b=0x40400000, sub=1 → `out`=0x00000000, flags=0, only `done[1]` pulses.
- Simultaneous go on req0/req1 from reset, both held until done → req0 served first, req1 `done` 3 cycles later. Repeat → order alternates, no starvation.
- Invalid: a=0x7F800000, b=0x7F800000, sub=1 → `out`=0x7FC00000, flags=5'b10000.
- Reset asserted during EXEC → no `done`, all outputs 0 on the next cycle, `rr_ptr`=0. Re-request completes normally.
- With `ADD_FN_ARB_OUT_REG_EN` defined → same results as above with `done` at t+3 and throughput of one per 4 cycles.
